// File: rtl/wb_write_queue.sv
// ---------------------------------------------------------------------------
// wb_write_queue
//
// Purpose:
//   Small circular writeback queue sitting in front of a register file.
//   Results are enqueued in acceptance order and drained one per cycle while
//   wb_stall is low. Writes to the protected registers 14 and 15 are accepted
//   but discarded, and counted in a saturating drop counter. An optional
//   bypass lookup reports the youngest queued write to a given register.
//
// Configuration:
//   DEPTH          queue entry count; legal values are 2, 4 and 8.
//   WBQ_BYPASS_EN  when defined, the lk_hit/lk_data lookup is built;
//                  when undefined, lk_hit/lk_data read 0 and lk_reg is unused.
//
// Ports:
//   clk          in   1   single clock, all state changes on posedge
//   reset        in   1   synchronous, active-high
//   in_valid     in   1   writeback result offered
//   in_dReg      in   4   destination register of the offered result
//   in_data      in  32   offered result data
//   in_ready     out  1   offered result is accepted this cycle
//   wb_stall     in   1   blocks draining while high
//   writeEnable  out  1   register-file write strobe (combinational)
//   dReg         out  4   register-file write index (head entry, 0 if empty)
//   wrData       out 32   register-file write data (head entry, 0 if empty)
//   lk_reg       in   4   bypass lookup index
//   lk_hit       out  1   a queued write to lk_reg exists
//   lk_data      out 32   data of the youngest queued write to lk_reg
//   count        out  4   number of valid entries
//   drop_cnt     out  8   saturating count of dropped protected writes
// ---------------------------------------------------------------------------
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  in_dReg,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        wb_stall,
    output logic        writeEnable,
    output logic [3:0]  dReg,
    output logic [31:0] wrData,
    input  logic [3:0]  lk_reg,
    output logic        lk_hit,
    output logic [31:0] lk_data,
    output logic [3:0]  count,
    output logic [7:0]  drop_cnt
);

    localparam int         PW      = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [3:0]       r_count;
    logic [7:0]       r_drop;
    logic [3:0]       r_idx [DEPTH];
    logic [31:0]      r_dat [DEPTH];
    logic [DEPTH-1:0] r_vld;

    logic w_head_vld;
    logic w_pop;
    logic w_ready;
    logic w_accept;
    logic w_prot;
    logic w_push;
    logic w_drop;

    // Valid entries are contiguous from head, so the head flag alone says
    // whether the queue is non-empty.
    assign w_head_vld = r_vld[r_head];

    // Gated by reset so pending entries never reach the register file once
    // reset is asserted.
    assign w_pop    = w_head_vld & ~wb_stall & ~reset;

    // A full queue only accepts when the head drains at the same edge.
    assign w_ready  = ~reset & ((r_count < DEPTH_C) | ((r_count != 4'd0) & ~wb_stall));
    assign w_accept = in_valid & w_ready;
    assign w_prot   = (in_dReg[3:1] == 3'b111);
    assign w_push   = w_accept & ~w_prot;
    assign w_drop   = w_accept & w_prot;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= '0;
            r_vld   <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PW'(1);
            end
            // When full, head == tail: the push's set of the valid flag
            // comes later and overrides the pop's clear of the same slot.
            if (w_push) begin
                r_idx[r_tail] <= in_dReg;
                r_dat[r_tail] <= in_data;
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign in_ready    = w_ready;
    assign writeEnable = w_pop;
    assign dReg        = w_head_vld ? r_idx[r_head] : '0;
    assign wrData      = w_head_vld ? r_dat[r_head] : '0;
    assign count       = r_count;
    assign drop_cnt    = r_drop;

`ifdef WBQ_BYPASS_EN
    logic          w_hit;
    logic [31:0]   w_hdata;
    logic [PW-1:0] w_slot;

    // Walk slots oldest to youngest; a later match overrides an earlier one
    // so the youngest queued write wins.
    always_comb begin
        w_hit   = 1'b0;
        w_hdata = '0;
        w_slot  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_slot = r_head + PW'(i);
            if (r_vld[w_slot] && (r_idx[w_slot] == lk_reg) && (lk_reg[3:1] != 3'b111)) begin
                w_hit   = 1'b1;
                w_hdata = r_dat[w_slot];
            end
        end
    end

    assign lk_hit  = w_hit;
    assign lk_data = w_hdata;
`else
    logic w_unused_lk;

    assign w_unused_lk = ^lk_reg;
    assign lk_hit      = 1'b0;
    assign lk_data     = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_write_queue
//
// Purpose:
//   Self-checking bench for wb_write_queue (DEPTH=4). A queue-based reference
//   model predicts every output each cycle; directed scenarios are followed
//   by a randomized phase. Honours WBQ_BYPASS_EN for the lookup expectations.
// ---------------------------------------------------------------------------
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_dReg;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wb_stall;
    logic        writeEnable;
    logic [3:0]  dReg;
    logic [31:0] wrData;
    logic [3:0]  lk_reg;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;

    int   checks   = 0;
    int   failures = 0;
    ent_t q[$];
    int   drops    = 0;

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_dReg     (in_dReg),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .wb_stall    (wb_stall),
        .writeEnable (writeEnable),
        .dReg        (dReg),
        .wrData      (wrData),
        .lk_reg      (lk_reg),
        .lk_hit      (lk_hit),
        .lk_data     (lk_data),
        .count       (count),
        .drop_cnt    (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge against the
    // model, then advance the model at posedge.
    task automatic cycle(input logic v, input logic [3:0] d, input logic [31:0] dat,
                         input logic st, input logic rst, input logic [3:0] lk);
        logic        e_we;
        logic        e_rdy;
        logic [3:0]  e_dreg;
        logic [31:0] e_data;
        logic        e_hit;
        logic [31:0] e_lkd;
        ent_t        e;
        in_valid = v;
        in_dReg  = d;
        in_data  = dat;
        wb_stall = st;
        reset    = rst;
        lk_reg   = lk;
        @(negedge clk);
        e_we   = (q.size() != 0) && !st && !rst;
        e_rdy  = !rst && ((q.size() < DEPTH) || ((q.size() != 0) && !st));
        e_dreg = (q.size() != 0) ? q[0].idx : 4'd0;
        e_data = (q.size() != 0) ? q[0].data : 32'd0;
        e_hit  = 1'b0;
        e_lkd  = 32'd0;
`ifdef WBQ_BYPASS_EN
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].idx == lk) begin
                e_hit = 1'b1;
                e_lkd = q[i].data;
                break;
            end
        end
`endif
        chk("writeEnable", writeEnable, e_we);
        chk("in_ready", in_ready, e_rdy);
        chk("dReg", dReg, e_dreg);
        chk("wrData", wrData, e_data);
        chk("count", count, q.size());
        chk("drop_cnt", drop_cnt, drops);
        chk("lk_hit", lk_hit, e_hit);
        chk("lk_data", lk_data, e_lkd);
        @(posedge clk);
        if (rst) begin
            q.delete();
            drops = 0;
        end else begin
            if (e_we) void'(q.pop_front());
            if (v && e_rdy) begin
                if (d >= 4'd14) begin
                    if (drops < 255) drops++;
                end else begin
                    e.idx  = d;
                    e.data = dat;
                    q.push_back(e);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, st, 1'b0, 4'd0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_dReg  = '0;
        in_data  = '0;
        wb_stall = 1'b0;
        lk_reg   = '0;

        // Reset and post-reset state
        cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 4'd0);
        cycle(1'b1, 4'd3, 32'h1234, 1'b0, 1'b1, 4'd3);
        idle(1, 1'b0);

        // Single write, one-cycle latency
        cycle(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 1'b0, 4'd3);
        chk("lat_we", writeEnable, 1'b1);
        chk("lat_dReg", dReg, 4'd3);
        chk("lat_wrData", wrData, 32'hDEADBEEF);
        idle(1, 1'b0);
        chk("lat_count_back", count, 4'd0);

        // Stalled fill: 4 accepted, 5th refused; release drains in order
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 1), 32'hA0 + 32'(i), 1'b1, 1'b0, 4'd0);
        chk("stall_full_count", count, 4'd4);
        chk("stall_5th_ready", in_ready, 1'b0);
        cycle(1'b1, 4'd5, 32'hA4, 1'b0, 1'b0, 4'd0);
        idle(6, 1'b0);

        // Protected registers are dropped with a saturating counter
        cycle(1'b1, 4'd14, 32'h77, 1'b0, 1'b0, 4'd14);
        cycle(1'b1, 4'd15, 32'h78, 1'b0, 1'b0, 4'd15);
        chk("drop_two", drop_cnt, 8'd2);
        chk("drop_no_we", writeEnable, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 4'(14 + (i % 2)), 32'(i), 1'b0, 1'b0, 4'd0);
        chk("drop_sat", drop_cnt, 8'd255);

        // Bypass: youngest matching entry wins
        cycle(1'b1, 4'd5, 32'h1, 1'b1, 1'b0, 4'd5);
        cycle(1'b1, 4'd5, 32'h2, 1'b1, 1'b0, 4'd5);
        cycle(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd5);
`ifdef WBQ_BYPASS_EN
        chk("byp_hit", lk_hit, 1'b1);
        chk("byp_data", lk_data, 32'h2);
`else
        chk("byp_hit_off", lk_hit, 1'b0);
        chk("byp_data_off", lk_data, 32'h0);
`endif
        idle(3, 1'b0);

        // Full queue streaming with pointer wrap over several laps
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i), 32'hB00 + 32'(i), 1'b1, 1'b0, 4'd2);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 4'(i % 14), 32'hC000 + 32'(i), 1'b0, 1'b0, 4'(i % 14));
            chk("wrap_count", count, 4'd4);
        end
        idle(5, 1'b0);

        // Reset with pending entries discards them
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'(7 + i), 32'hE0 + 32'(i), 1'b1, 1'b0, 4'd8);
        cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 4'd8);
        chk("rst_pend_count", count, 4'd0);
        cycle(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd8);
        chk("rst_pend_we", writeEnable, 1'b0);
        chk("rst_pend_data", wrData, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  4'($urandom_range(0, 15)),
                  $urandom(),
                  1'($urandom_range(0, 9) < 4),
                  1'($urandom_range(0, 59) == 0),
                  4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
